// File: rtl/jtag_tap.sv
// ============================================================================
//  Module   : jtag_tap
//  Purpose  : JTAG test access port. 16-state TAP controller, IR_W-bit
//             instruction register with decode, BSR_LEN-cell boundary scan
//             register, 1-bit bypass register and optional 32-bit IDCODE
//             register, all clocked by TCK.
//  Ports    : TCK       - test clock, all state updates on the rising edge
//             TRST_N    - asynchronous active-low reset
//             TMS       - mode select, sampled on rising TCK
//             TDI       - serial data in
//             sys_in    - system data from core/pins (BSR_LEN bits)
//             TDO       - serial data out (combinational)
//             sys_out   - system data to pins/core (BSR_LEN bits)
//             tap_state - current TAP state code (4 bits)
//             inst      - active (updated) instruction (IR_W bits)
//  Options  : JTAG_IDCODE_EN - when defined, the IDCODE register exists,
//             opcode 2 selects it and the default instruction is IDCODE.
//             When undefined, opcode 2 acts as BYPASS and the default
//             instruction is BYPASS.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tap #(
    parameter int          IR_W       = 4,
    parameter int          BSR_LEN    = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0A1B
) (
    input  logic               TCK,
    input  logic               TRST_N,
    input  logic               TMS,
    input  logic               TDI,
    input  logic [BSR_LEN-1:0] sys_in,
    output logic               TDO,
    output logic [BSR_LEN-1:0] sys_out,
    output logic [3:0]         tap_state,
    output logic [IR_W-1:0]    inst
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    generate
        if (IR_W < 2) begin : g_bad_ir_w
            $error("jtag_tap: IR_W must be at least 2");
        end
        if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
            $error("jtag_tap: IDCODE_VAL bit 0 must be 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [IR_W-1:0] c_op_extest  = '0;
    localparam logic [IR_W-1:0] c_op_sample  = IR_W'(1);
    localparam logic [IR_W-1:0] c_op_bypass  = '1;
    // IR capture pattern ...01 lets a scan detect a broken IR chain.
    localparam logic [IR_W-1:0] c_ir_capture = IR_W'(1);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] c_op_idcode  = IR_W'(2);
    localparam logic [IR_W-1:0] c_def_inst   = c_op_idcode;
`else
    localparam logic [IR_W-1:0] c_def_inst   = c_op_bypass;
`endif

    typedef enum logic [3:0] {
        ST_TLR      = 4'd0,
        ST_RTI      = 4'd1,
        ST_SEL_DR   = 4'd2,
        ST_CAP_DR   = 4'd3,
        ST_SHIFT_DR = 4'd4,
        ST_EXIT1_DR = 4'd5,
        ST_PAUSE_DR = 4'd6,
        ST_EXIT2_DR = 4'd7,
        ST_UPD_DR   = 4'd8,
        ST_SEL_IR   = 4'd9,
        ST_CAP_IR   = 4'd10,
        ST_SHIFT_IR = 4'd11,
        ST_EXIT1_IR = 4'd12,
        ST_PAUSE_IR = 4'd13,
        ST_EXIT2_IR = 4'd14,
        ST_UPD_IR   = 4'd15
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next;
    logic [IR_W-1:0]    r_ir_shift;
    logic [IR_W-1:0]    r_inst;
    logic [BSR_LEN-1:0] r_bsr_shift;
    logic [BSR_LEN-1:0] r_bsr_upd;
    logic               r_bypass;
    logic               w_sel_bsr;
    logic               w_sel_id;
    logic               w_sel_byp;
    logic               w_dr_tdo;
`ifdef JTAG_IDCODE_EN
    logic [31:0]        r_id_shift;
`endif

    // ------------------------------------------------------------------
    // TAP controller
    // ------------------------------------------------------------------
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_TLR:      w_next = TMS ? ST_TLR      : ST_RTI;
            ST_RTI:      w_next = TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   w_next = TMS ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   w_next = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: w_next = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: w_next = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: w_next = TMS ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: w_next = TMS ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   w_next = TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   w_next = TMS ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   w_next = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: w_next = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: w_next = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: w_next = TMS ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: w_next = TMS ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   w_next = TMS ? ST_SEL_DR   : ST_RTI;
            default:     w_next = ST_TLR;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction register. Register actions are keyed on the current
    // state, so each takes effect on the edge that leaves (or stays in)
    // that state, together with the state transition.
    // ------------------------------------------------------------------
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_ir_shift <= c_ir_capture;
            r_inst     <= c_def_inst;
        end else begin
            if (r_state == ST_CAP_IR) begin
                r_ir_shift <= c_ir_capture;
            end else if (r_state == ST_SHIFT_IR) begin
                r_ir_shift <= {TDI, r_ir_shift[IR_W-1:1]};
            end

            if (r_state == ST_TLR) begin
                r_inst <= c_def_inst;
            end else if (r_state == ST_UPD_IR) begin
                r_inst <= r_ir_shift;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data register selection. Unrecognised opcodes fall through to bypass.
    // ------------------------------------------------------------------
    assign w_sel_bsr = (r_inst == c_op_extest) || (r_inst == c_op_sample);
`ifdef JTAG_IDCODE_EN
    assign w_sel_id  = (r_inst == c_op_idcode);
`else
    assign w_sel_id  = 1'b0;
`endif
    assign w_sel_byp = !w_sel_bsr && !w_sel_id;

    // ------------------------------------------------------------------
    // Boundary scan register: shift stage plus update stage
    // ------------------------------------------------------------------
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_bsr_shift <= '0;
            r_bsr_upd   <= '0;
        end else if (w_sel_bsr) begin
            case (r_state)
                ST_CAP_DR:   r_bsr_shift <= sys_in;
                ST_SHIFT_DR: r_bsr_shift <= {TDI, r_bsr_shift[BSR_LEN-1:1]};
                ST_UPD_DR:   r_bsr_upd   <= r_bsr_shift;
                default:     ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bypass register
    // ------------------------------------------------------------------
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_bypass <= 1'b0;
        end else if (w_sel_byp) begin
            if (r_state == ST_CAP_DR) begin
                r_bypass <= 1'b0;
            end else if (r_state == ST_SHIFT_DR) begin
                r_bypass <= TDI;
            end
        end
    end

`ifdef JTAG_IDCODE_EN
    // ------------------------------------------------------------------
    // IDCODE register
    // ------------------------------------------------------------------
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_id_shift <= IDCODE_VAL;
        end else if (w_sel_id) begin
            if (r_state == ST_CAP_DR) begin
                r_id_shift <= IDCODE_VAL;
            end else if (r_state == ST_SHIFT_DR) begin
                r_id_shift <= {TDI, r_id_shift[31:1]};
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Serial output
    // ------------------------------------------------------------------
    always_comb begin
        w_dr_tdo = r_bypass;
        if (w_sel_bsr) begin
            w_dr_tdo = r_bsr_shift[0];
        end
`ifdef JTAG_IDCODE_EN
        else if (w_sel_id) begin
            w_dr_tdo = r_id_shift[0];
        end
`endif
    end

    always_comb begin
        TDO = 1'b0;
        if (r_state == ST_SHIFT_IR) begin
            TDO = r_ir_shift[0];
        end else if (r_state == ST_SHIFT_DR) begin
            TDO = w_dr_tdo;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sys_out   = (r_inst == c_op_extest) ? r_bsr_upd : sys_in;
    assign tap_state = r_state;
    assign inst      = r_inst;

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap.sv
// ============================================================================
//  Module   : tb_jtag_tap
//  Purpose  : Self-checking bench for jtag_tap. A vector table walks the
//             TAP through an IR load and a bypass scan; hand-written
//             sequences cover SAMPLE with pause, EXTEST update, async abort
//             and the default-instruction DR scan (IDCODE or BYPASS).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_tap;

    localparam int          IR_W       = 4;
    localparam int          BSR_LEN    = 8;
    localparam logic [31:0] IDCODE_VAL = 32'h1000_0A1B;
`ifdef JTAG_IDCODE_EN
    localparam logic [3:0]  DEF_INST   = 4'h2;
`else
    localparam logic [3:0]  DEF_INST   = 4'hF;
`endif

    logic               TCK;
    logic               TRST_N;
    logic               TMS;
    logic               TDI;
    logic [BSR_LEN-1:0] sys_in;
    logic               TDO;
    logic [BSR_LEN-1:0] sys_out;
    logic [3:0]         tap_state;
    logic [IR_W-1:0]    inst;

    int n_checks = 0;
    int n_err    = 0;

    jtag_tap #(
        .IR_W       (IR_W),
        .BSR_LEN    (BSR_LEN),
        .IDCODE_VAL (IDCODE_VAL)
    ) dut (
        .TCK       (TCK),
        .TRST_N    (TRST_N),
        .TMS       (TMS),
        .TDI       (TDI),
        .sys_in    (sys_in),
        .TDO       (TDO),
        .sys_out   (sys_out),
        .tap_state (tap_state),
        .inst      (inst)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    // Expected values after the edge: state, optional TDO, optional inst.
    typedef struct {
        bit         tms;
        bit         tdi;
        logic [3:0] st;
        bit         chk_tdo;
        bit         tdo;
        bit         chk_inst;
        logic [3:0] ins;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One TCK edge with the given TMS/TDI; returns 1 time unit after the edge.
    task automatic step(input bit tms, input bit tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    // From RTI: load an instruction LSB-first and return to RTI.
    task automatic load_ir(input logic [3:0] code);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < IR_W; i++) begin
            step(i == IR_W - 1, code[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check($sformatf("load_ir_inst_%0h", code), 32'(inst), 32'(code));
        check("load_ir_state_rti", 32'(tap_state), 32'd1);
    endtask

    // From RTI or TLR (TMS=0 edge first): enter SHIFT_DR.
    task automatic enter_shift_dr();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("enter_shift_dr", 32'(tap_state), 32'd4);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0]  pat;
        logic [31:0] idv;

        TRST_N = 1'b0;
        TMS    = 1'b1;
        TDI    = 1'b0;
        sys_in = 8'h11;
        #12;
        check("rst_state", 32'(tap_state), 32'd0);
        check("rst_inst", 32'(inst), 32'(DEF_INST));
        check("rst_tdo", 32'(TDO), 32'd0);
        check("rst_sys_out", 32'(sys_out), 32'(sys_in));
        TRST_N = 1'b1;
        @(posedge TCK);
        #1;
        check("rst_hold_tlr", 32'(tap_state), 32'd0);

        // ---------------- table: IR load to BYPASS, bypass scan, TLR walk
        //                  tms   tdi   st     ctdo  tdo   cins  ins
        vecs.push_back('{1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b1, DEF_INST});
        vecs.push_back('{1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b0, 4'd11, 1'b1, 1'b1, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b1, 4'd12, 1'b1, 1'b0, 1'b1, DEF_INST});
        vecs.push_back('{1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1, DEF_INST});
        vecs.push_back('{1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b1, 4'hF});
        vecs.push_back('{1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b1, 4'd4,  1'b1, 1'b1, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'hF});
        vecs.push_back('{1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b1, DEF_INST});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].tms, vecs[i].tdi);
            check($sformatf("vec%0d_state", i), 32'(tap_state), 32'(vecs[i].st));
            if (vecs[i].chk_tdo) begin
                check($sformatf("vec%0d_tdo", i), 32'(TDO), 32'(vecs[i].tdo));
            end
            if (vecs[i].chk_inst) begin
                check($sformatf("vec%0d_inst", i), 32'(inst), 32'(vecs[i].ins));
            end
        end

        // ---------------- SAMPLE with a pause in the middle of the shift
        load_ir(4'h1);
        sys_in = 8'hA5;
        pat    = 8'hA5;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("sample_state_shift", 32'(tap_state), 32'd4);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sample_tdo_%0d", i), 32'(TDO), 32'(pat[i]));
            check($sformatf("sample_sys_out_%0d", i), 32'(sys_out), 32'(sys_in));
            if (i == 3) begin
                step(1'b1, 1'b0);
                step(1'b0, 1'b0);
                check("sample_pause_state", 32'(tap_state), 32'd6);
                check("sample_pause_tdo", 32'(TDO), 32'd0);
                step(1'b0, 1'b0);
                step(1'b1, 1'b0);
                step(1'b0, 1'b0);
                check("sample_resume_state", 32'(tap_state), 32'd4);
            end else begin
                step(i == 7, 1'b0);
            end
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        sys_in = 8'h5A;
        #1;
        check("sample_passthru", 32'(sys_out), 32'h5A);

        // ---------------- EXTEST: shift in 3C, update, sys_in isolated
        load_ir(4'h0);
        check("extest_upd_initial", 32'(sys_out), 32'h00);
        pat = 8'h3C;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("extest_cap_tdo_%0d", i), 32'(TDO), 32'(sys_in[i]));
            step(i == 7, pat[i]);
        end
        check("extest_before_upd", 32'(sys_out), 32'h00);
        step(1'b1, 1'b0);
        check("extest_in_upd_state", 32'(sys_out), 32'h00);
        step(1'b0, 1'b0);
        check("extest_after_upd", 32'(sys_out), 32'h3C);
        sys_in = 8'hFF;
        #1;
        check("extest_isolated", 32'(sys_out), 32'h3C);

        // ---------------- async abort mid-SHIFT_DR
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        #2;
        TRST_N = 1'b0;
        #1;
        check("abort_state", 32'(tap_state), 32'd0);
        check("abort_sys_out", 32'(sys_out), 32'hFF);
        check("abort_tdo", 32'(TDO), 32'd0);
        check("abort_inst", 32'(inst), 32'(DEF_INST));
        TMS = 1'b1;
        #2;
        TRST_N = 1'b1;
        @(posedge TCK);
        #1;
        check("abort_release_tlr", 32'(tap_state), 32'd0);

        // ---------------- DR scan of the default instruction
        enter_shift_dr();
`ifdef JTAG_IDCODE_EN
        idv = IDCODE_VAL;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("idcode_tdo_%0d", i), 32'(TDO), 32'(idv[i]));
            step(i == 31, 1'b0);
        end
`else
        idv = 32'h0;
        check("def_byp_tdo_0", 32'(TDO), idv);
        step(1'b0, 1'b1);
        check("def_byp_tdo_1", 32'(TDO), 32'd1);
        step(1'b0, 1'b1);
        check("def_byp_tdo_2", 32'(TDO), 32'd1);
        step(1'b1, 1'b1);
`endif
        check("def_scan_exit1", 32'(tap_state), 32'd5);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // BSR update register must have been cleared by the abort
        load_ir(4'h0);
        check("abort_upd_cleared", 32'(sys_out), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
